fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch stage with a one-entry decode buffer.
// Optional macro FETCH_BRANCH_PRED_EN enables use of pred_taken/pred_target.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] pc_f,
  input  logic        pred_taken,
  input  logic [31:0] pred_target,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_d,
  output logic [31:0] pc_d,
  output logic        pred_taken_d
);

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_e;

  state_e      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] fl_pc_q, fl_pc_d;
  logic        fl_pred_q, fl_pred_d;
  logic        dec_vld_q, dec_vld_d;
  logic [31:0] dec_instr_q, dec_instr_d;
  logic [31:0] dec_pc_q, dec_pc_d;
  logic        dec_pred_q, dec_pred_d;

  logic        buf_free, accept, rsp_take, take_pred;
  logic [31:0] pc_plus4, next_seq;

  assign pc_plus4 = fetch_pc_q + 32'd4;
  assign buf_free = !dec_vld_q || instr_ready;
  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_take = (state_q == WAIT) && imem_rsp_valid && !redirect_valid;

`ifdef FETCH_BRANCH_PRED_EN
  assign take_pred = pred_taken;
  assign next_seq  = pred_taken ? pred_target : pc_plus4;
  logic unused_sig;
  assign unused_sig = ^redirect_pc[1:0];
`else
  assign take_pred = 1'b0;
  assign next_seq  = pc_plus4;
  logic unused_sig;
  assign unused_sig = ^{pred_taken, pred_target, redirect_pc[1:0]};
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (accept) state_d = WAIT;
      WAIT: begin
        if (redirect_valid)      state_d = imem_rsp_valid ? IDLE : DRAIN;
        else if (imem_rsp_valid) state_d = IDLE;
      end
      // The response that lands here belongs to a flushed request, even if
      // another redirect arrives alongside it.
      DRAIN: if (imem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    imem_req_valid = !reset && (state_q == IDLE) && !redirect_valid && buf_free;
    imem_addr      = fetch_pc_q;
    pc_f           = fetch_pc_q;
    instr_valid    = dec_vld_q;
    instr_d        = dec_instr_q;
    pc_d           = dec_pc_q;
    pred_taken_d   = dec_pred_q;
  end

  // Datapath next values
  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    fl_pc_d     = fl_pc_q;
    fl_pred_d   = fl_pred_q;
    dec_vld_d   = dec_vld_q;
    dec_instr_d = dec_instr_q;
    dec_pc_d    = dec_pc_q;
    dec_pred_d  = dec_pred_q;
    if (redirect_valid) begin
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
    end else if (accept) begin
      fetch_pc_d = next_seq;
      fl_pc_d    = fetch_pc_q;
      fl_pred_d  = take_pred;
    end
    if (rsp_take) begin
      dec_vld_d   = 1'b1;
      dec_instr_d = imem_rsp_data;
      dec_pc_d    = fl_pc_q;
      dec_pred_d  = fl_pred_q;
    end else if (redirect_valid || (dec_vld_q && instr_ready)) begin
      dec_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q  <= RESET_PC;
      fl_pc_q     <= '0;
      fl_pred_q   <= 1'b0;
      dec_vld_q   <= 1'b0;
      dec_instr_q <= '0;
      dec_pc_q    <= '0;
      dec_pred_q  <= 1'b0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      fl_pc_q     <= fl_pc_d;
      fl_pred_q   <= fl_pred_d;
      dec_vld_q   <= dec_vld_d;
      dec_instr_q <= dec_instr_d;
      dec_pc_q    <= dec_pc_d;
      dec_pred_q  <= dec_pred_d;
    end
  end

endmodule
